// File: rtl/dip_debounce_if.sv
// Switch-bank signal bundle: raw levels and toggle clear in, conditioned levels,
// edge pulses, toggle latches and settle flag out.
interface dip_debounce_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] sw_in;
   logic             clear_toggle;
   logic [WIDTH-1:0] sw_state;
   logic [WIDTH-1:0] sw_rise;
   logic [WIDTH-1:0] sw_fall;
   logic             any_change;
   logic [WIDTH-1:0] toggle_state;
   logic             sw_valid;

   // No handshake: sw_in is a free-running level, and every output is a plain
   // registered level or a one-cycle pulse. A consumer should ignore the
   // outputs until sw_valid is high.
   modport master (
      output sw_in, clear_toggle,
      input  sw_state, sw_rise, sw_fall, any_change, toggle_state, sw_valid
   );

   modport slave (
      input  sw_in, clear_toggle,
      output sw_state, sw_rise, sw_fall, any_change, toggle_state, sw_valid
   );
endinterface

// File: rtl/dip_debounce.sv
// Mechanical switch conditioner: per-channel synchroniser, debounce counter, optional
// inversion, edge pulses and toggle latches, with pulses muted until start-up settles.
module dip_debounce #(
   parameter int               WIDTH           = 8,
   parameter int               DEBOUNCE_CYCLES = 500000,
   parameter int               SYNC_STAGES     = 2,
   parameter logic [WIDTH-1:0] INVERT          = '0
) (
   input logic          clk,
   input logic          rst,
   dip_debounce_if.slave bus
);

   localparam int              CW          = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0]   CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
   localparam int              SETTLE      = SYNC_STAGES + DEBOUNCE_CYCLES;
   localparam int              SW          = $clog2(SETTLE + 1);
   localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [CW-1:0]    cnt_q  [WIDTH];
   logic [CW-1:0]    cnt_d  [WIDTH];
   logic [WIDTH-1:0] synced;
   logic [WIDTH-1:0] accept;
   logic [WIDTH-1:0] rise_d;
   logic [WIDTH-1:0] fall_d;
   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] fall_q;
   logic [WIDTH-1:0] toggle_q;
   logic             change_q;
   logic             valid_q;
   logic [SW-1:0]    settle_q;

   assign synced = sync_q[SYNC_STAGES-1] ^ INVERT;

   // A channel's count only survives while synced disagrees with the accepted
   // level; any agreement, however brief, restarts it from zero.
   always_comb begin
      accept = '0;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (synced[i] != state_q[i]) begin
            if (cnt_q[i] == CNT_LAST) accept[i] = 1'b1;
            else                      cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
      if (valid_q) begin
         rise_d = accept & synced;
         fall_d = accept & ~synced;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         for (int i = 0; i < WIDTH; i++)       cnt_q[i]  <= '0;
         state_q  <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         change_q <= 1'b0;
         toggle_q <= '0;
         valid_q  <= 1'b0;
         settle_q <= '0;
      end else begin
         sync_q[0] <= bus.sw_in;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         for (int i = 0; i < WIDTH; i++)       cnt_q[i]  <= cnt_d[i];
         state_q  <= state_q ^ accept;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         change_q <= |(rise_d | fall_d);
         // Clear has priority so a rise landing on the clear edge is dropped.
         if (bus.clear_toggle) toggle_q <= '0;
         else                  toggle_q <= toggle_q ^ rise_q;
         if (!valid_q) begin
            if (settle_q == SETTLE_LAST) valid_q  <= 1'b1;
            else                         settle_q <= settle_q + SW'(1);
         end
      end
   end

   assign bus.sw_state     = state_q;
   assign bus.sw_rise      = rise_q;
   assign bus.sw_fall      = fall_q;
   assign bus.any_change   = change_q;
   assign bus.toggle_state = toggle_q;
   assign bus.sw_valid     = valid_q;

endmodule

// File: doc/dip_debounce.md
Name: dip_debounce

Overview:
Parametrised conditioner for banks of external mechanical switches, such as the trainer DIP bank, before they reach LEDs or control logic. Each channel is synchronised into the clk domain, debounced with a per-channel counter, and optionally inverted. The block produces a clean level, one-cycle rise/fall pulses, a change strobe, and a per-channel toggle latch. Pulses are suppressed during a post-reset settling window so held switches are loaded silently.

Parameters:
WIDTH, 8, number of switch channels (>=1)
DEBOUNCE_CYCLES, 500000, consecutive clk cycles a new level must persist before acceptance (10 ms at 50 MHz; >=2)
SYNC_STAGES, 2, synchroniser flop depth per channel (>=2)
INVERT, {WIDTH{1'b0}}, per-bit mask XORed onto the synchronised input; 1 = active-low switch

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
sw_in  input  WIDTH  raw asynchronous switch levels
clear_toggle  input  1  synchronous clear of toggle_state
sw_state  output  WIDTH  debounced level per channel
sw_rise  output  WIDTH  one-cycle pulse when sw_state goes 0->1
sw_fall  output  WIDTH  one-cycle pulse when sw_state goes 1->0
any_change  output  1  one-cycle pulse, OR of sw_rise|sw_fall
toggle_state  output  WIDTH  flips on each sw_rise of that channel
sw_valid  output  1  high once the post-reset settling window has elapsed

Behaviour:
- Reset (rst=1 at an edge): sync chain, counters, sw_state, sw_rise, sw_fall, any_change, toggle_state, sw_valid and startup counter all go to 0. Reset mid-debounce discards partial counts with no pulse.
- Sync: SYNC_STAGES flops per bit. Define synced = last stage XOR INVERT.
- Debounce per channel, counter width max(1,$clog2(DEBOUNCE_CYCLES)):
  - If synced==sw_state: counter <= 0.
  - Else if counter==DEBOUNCE_CYCLES-1: sw_state <= synced and counter <= 0.
  - Else: counter++.
  - Any glitch shorter than DEBOUNCE_CYCLES resets the count. No change is accepted.
- Latency: a level first sampled on edge 1 that is held stable updates sw_state on edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Pulses: sw_rise/sw_fall are registered and assert in the same cycle sw_state changes, for exactly one cycle. any_change = OR-reduce of both, registered alongside them.
- Startup: sw_valid rises on edge SYNC_STAGES+DEBOUNCE_CYCLES+1 after the last rst=1 edge, then stays high until reset.
  - A sw_state update on an edge where sw_valid (pre-edge value) is 0 produces no sw_rise, sw_fall or any_change, and does not affect toggle_state.
- Toggle: on an edge with sw_rise[i]=1, toggle_state[i] flips.
  - clear_toggle=1 forces all bits to 0. Clear wins over a simultaneous rise.
- Channels are independent. Simultaneous changes on several channels each produce their own pulse in the same cycle, and any_change stays high for one cycle only.
- Continuous bouncing faster than DEBOUNCE_CYCLES holds sw_state indefinitely.

Test Plan:
(Bench uses WIDTH=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2, INVERT=4'b1000.)
1. Reset, then sw_in=4'b0001 held -> sw_state=4'b1001 after edge 6, no pulses, sw_valid=1 at edge 7, toggle_state=0.
2. After valid, sw_in[1] 0->1 held -> sw_state[1]=1 and sw_rise=4'b0010 on edge 6 from first sample, any_change=1 for one cycle, toggle_state[1]=1.
3. sw_in[1] glitches low for 3 cycles then returns high -> no sw_state change and no pulses. Low held for 4+ cycles -> sw_fall[1] pulse, toggle_state unchanged.
4. sw_in[0] and sw_in[2] change in the same cycle -> sw_rise/sw_fall bits for channels 0 and 2 in the same cycle, any_change high exactly one cycle.
5. clear_toggle asserted on the same edge as sw_rise[1] -> toggle_state=4'b0000. Next rise -> 4'b0010.
6. rst asserted mid-debounce (counter=2) -> all outputs 0 next cycle. Startup window repeats and held switch levels load with no pulses.
